// File: rtl/matrix_mac_unit_pkg.sv
// Shared definitions for the matrix MAC unit.
//   mmac_op_t : op encodings driven on the 2-bit op port (MAC, CLR, LOAD, READ).
//   sum_width : width at which a MAC element sum is formed, wide enough that
//               the true sum never wraps before overflow is judged.
package matrix_mac_unit_pkg;

  typedef enum logic [1:0] {
    MMAC_OP_MAC  = 2'd0,
    MMAC_OP_CLR  = 2'd1,
    MMAC_OP_LOAD = 2'd2,
    MMAC_OP_READ = 2'd3
  } mmac_op_t;

  function automatic int unsigned sum_width(input int unsigned acc_w, input int unsigned ew);
    return acc_w + 2 * ew + 1;
  endfunction

endpackage

// File: rtl/matrix_mac_row.sv
// One accumulator row r of the N x N tile.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : pipeline advance (low while the read port is back-pressured)
//   a          : op_A lanes at issue; S1 captures a[c]*b for every column c
//   b          : op_B lane r
//   mac/clr/load : S2 commit strobes (already qualified by the top)
//   sat_en     : S1 saturate flag for the committing MAC
//   load_data  : S1 op_A lanes used by LOAD (zero/sign-extended)
//   acc_row    : acc[r][c] at [c*ACC_W +: ACC_W]
//   ovf        : some lane of this row overflows if the S1 MAC commits now
module matrix_mac_row
  import matrix_mac_unit_pkg::*;
#(
  parameter int N      = 4,
  parameter int EW     = 8,
  parameter int ACC_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N*EW-1:0]    a,
  input  logic [EW-1:0]      b,
  input  logic               mac,
  input  logic               clr,
  input  logic               load,
  input  logic               sat_en,
  input  logic [N*EW-1:0]    load_data,
  output logic [N*ACC_W-1:0] acc_row,
  output logic               ovf
);

  localparam int PW   = 2 * EW;
  localparam int SW   = int'(sum_width(ACC_W, EW));
  localparam bit IS_S = (SIGNED != 0);
  localparam logic [ACC_W-1:0] SAT_MAX = {~IS_S, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {IS_S, {(ACC_W-1){1'b0}}};

  logic [PW-1:0]    prod_d [N];
  logic [PW-1:0]    prod   [N];
  logic [ACC_W-1:0] acc    [N];
  logic [ACC_W-1:0] nxt    [N];
  logic [ACC_W-1:0] ld     [N];
  logic [SW-1:0]    sum    [N];
  logic [N-1:0]     lane_ovf;

  always_comb begin
    for (int unsigned c = 0; c < N; c++) begin
      if (IS_S) begin
        prod_d[c] = PW'($signed(a[c*EW +: EW])) * PW'($signed(b));
        ld[c]     = ACC_W'($signed(load_data[c*EW +: EW]));
        sum[c]    = SW'($signed(acc[c])) + SW'($signed(prod[c]));
        // In range only if every bit from the ACC_W sign bit upward agrees
        lane_ovf[c] = !((&sum[c][SW-1:ACC_W-1]) || !(|sum[c][SW-1:ACC_W-1]));
      end else begin
        prod_d[c]   = PW'(a[c*EW +: EW]) * PW'(b);
        ld[c]       = ACC_W'(load_data[c*EW +: EW]);
        sum[c]      = SW'(acc[c]) + SW'(prod[c]);
        lane_ovf[c] = |sum[c][SW-1:ACC_W];
      end
      nxt[c] = sum[c][ACC_W-1:0];
      if (lane_ovf[c] && sat_en) nxt[c] = sum[c][SW-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    acc_row = '0;
    for (int unsigned c = 0; c < N; c++) acc_row[c*ACC_W +: ACC_W] = acc[c];
  end

  assign ovf = |lane_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < N; c++) begin
        prod[c] <= '0;
        acc[c]  <= '0;
      end
    end else begin
      if (en) begin
        for (int unsigned c = 0; c < N; c++) prod[c] <= prod_d[c];
      end
      for (int unsigned c = 0; c < N; c++) begin
        if (clr)       acc[c] <= '0;
        else if (load) acc[c] <= ld[c];
        else if (mac)  acc[c] <= nxt[c];
      end
    end
  end

endmodule

// File: rtl/matrix_mac_unit.sv
// Pipelined outer-product MAC engine holding an N x N accumulator tile.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : op issue handshake (op, sat_en, row_idx, op_A, op_B)
//   op                : MAC / CLR / LOAD / READ (matrix_mac_unit_pkg::mmac_op_t)
//   rd_valid/rd_ready : read-row handshake, row returned on rd_data
//   ovf               : sticky MAC overflow flag, cleared by CLR or reset
// S1 registers the op and the products; S2 commits into the tile or rd_data.
module matrix_mac_unit
  import matrix_mac_unit_pkg::*;
#(
  parameter int N      = 4,
  parameter int EW     = 8,
  parameter int ACC_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic                  sat_en,
  input  logic [$clog2(N)-1:0]  row_idx,
  input  logic [N*EW-1:0]       op_A,
  input  logic [N*EW-1:0]       op_B,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [N*ACC_W-1:0]    rd_data,
  output logic                  ovf
);

  localparam int RW = $clog2(N);

  logic             started;
  logic             stall;
  logic             accept;
  logic             commit;
  logic             s1_valid;
  mmac_op_t         s1_op;
  logic [RW-1:0]    s1_row;
  logic             s1_sat;
  logic [N*EW-1:0]  s1_a;
  logic [N*ACC_W-1:0] acc_rows [N];
  logic [N-1:0]     row_ovf;

  // A held row freezes the whole pipeline, so S2 never overtakes the consumer.
  assign stall    = rd_valid & ~rd_ready;
  assign in_ready = started & ~stall;
  assign accept   = in_valid & in_ready;
  assign commit   = s1_valid & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started  <= 1'b0;
      s1_valid <= 1'b0;
      s1_op    <= MMAC_OP_MAC;
      s1_row   <= '0;
      s1_sat   <= 1'b0;
      s1_a     <= '0;
    end else begin
      started <= 1'b1;
      if (!stall) begin
        s1_valid <= accept;
        s1_op    <= mmac_op_t'(op);
        s1_row   <= row_idx;
        s1_sat   <= sat_en;
        s1_a     <= op_A;
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    matrix_mac_row #(
      .N      (N),
      .EW     (EW),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
    ) u_row (
      .clk       (clk),
      .rst       (rst),
      .en        (~stall),
      .a         (op_A),
      .b         (op_B[r*EW +: EW]),
      .mac       (commit && (s1_op == MMAC_OP_MAC)),
      .clr       (commit && (s1_op == MMAC_OP_CLR)),
      .load      (commit && (s1_op == MMAC_OP_LOAD) && (s1_row == RW'(r))),
      .sat_en    (s1_sat),
      .load_data (s1_a),
      .acc_row   (acc_rows[r]),
      .ovf       (row_ovf[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      ovf      <= 1'b0;
    end else begin
      if (commit && (s1_op == MMAC_OP_READ)) begin
        rd_valid <= 1'b1;
        rd_data  <= acc_rows[s1_row];
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
      if (commit && (s1_op == MMAC_OP_CLR))      ovf <= 1'b0;
      else if (commit && (s1_op == MMAC_OP_MAC)) ovf <= ovf | (|row_ovf);
    end
  end

endmodule

// File: tb/tb_matrix_mac_unit.sv
// Self-checking bench for matrix_mac_unit: an unsigned 8-bit instance driven
// against a tile model and row scoreboard, plus a signed 16-bit instance.
module tb_matrix_mac_unit;
  import matrix_mac_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Unsigned 8-bit instance
  logic        in_valid = 1'b0, in_ready, sat_en = 1'b0, rd_valid, rd_ready = 1'b1, ovf;
  logic [1:0]  op = 2'd0, row_idx = 2'd0;
  logic [31:0] op_A = '0, op_B = '0, rd_data;

  // Signed 16-bit instance
  logic        s_in_valid = 1'b0, s_in_ready, s_sat_en = 1'b0, s_rd_valid, s_rd_ready = 1'b1, s_ovf;
  logic [1:0]  s_op = 2'd0, s_row_idx = 2'd0;
  logic [31:0] s_op_A = '0, s_op_B = '0;
  logic [63:0] s_rd_data;

  matrix_mac_unit #(.N(4), .EW(8), .ACC_W(8), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .sat_en(sat_en), .row_idx(row_idx), .op_A(op_A), .op_B(op_B),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .ovf(ovf)
  );

  matrix_mac_unit #(.N(4), .EW(8), .ACC_W(16), .SIGNED(1)) u_sdut (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .sat_en(s_sat_en), .row_idx(s_row_idx), .op_A(s_op_A), .op_B(s_op_B),
    .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_data(s_rd_data), .ovf(s_ovf)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference tile for the unsigned instance, updated in issue order
  logic [7:0]  m [4][4];
  logic        movf;
  logic [31:0] exp_q [$];
  bit          rand_bp = 1'b0;

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = 8'h00;
    movf = 1'b0;
  endtask

  task automatic model_apply(input mmac_op_t o, input int row, input logic [31:0] a,
                             input logic [31:0] b, input logic sat);
    int unsigned t;
    logic [31:0] rowv;
    case (o)
      MMAC_OP_MAC:
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            t = int'(m[r][c]) + int'(a[c*8 +: 8]) * int'(b[r*8 +: 8]);
            if (t > 255) begin
              movf = 1'b1;
              m[r][c] = sat ? 8'hFF : t[7:0];
            end else begin
              m[r][c] = t[7:0];
            end
          end
      MMAC_OP_CLR: model_reset();
      MMAC_OP_LOAD:
        for (int c = 0; c < 4; c++) m[row][c] = a[c*8 +: 8];
      default: begin
        for (int c = 0; c < 4; c++) rowv[c*8 +: 8] = m[row][c];
        exp_q.push_back(rowv);
      end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input mmac_op_t o, input int row, input logic [31:0] a,
                       input logic [31:0] b, input logic sat);
    int n;
    in_valid = 1'b1; op = o; row_idx = row[1:0]; op_A = a; op_B = b; sat_en = sat;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model_apply(o, row, a, b, sat);
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      n++;
      if (n > 40) begin
        check("accept_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("ovf", {63'd0, ovf}, {63'd0, movf});
    @(posedge clk); #1;
  endtask

  // Scoreboard: a row leaves the DUT when rd_valid and rd_ready are both high
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) check("rd_unexpected", {63'd0, rd_valid}, 64'd0);
      else check("rd_row", {32'd0, rd_data}, {32'd0, exp_q.pop_front()});
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) rd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic s_issue(input mmac_op_t o, input int row, input logic [31:0] a,
                         input logic [31:0] b, input logic sat);
    int n;
    s_in_valid = 1'b1; s_op = o; s_row_idx = row[1:0]; s_op_A = a; s_op_B = b; s_sat_en = sat;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_in_ready || n > 40) begin
        if (!s_in_ready) check("s_accept_timeout", {63'd0, s_in_ready}, 64'd1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        break;
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic s_read(input int row, input logic [63:0] exp, input string tag);
    int n;
    s_issue(MMAC_OP_READ, row, '0, '0, 1'b0);
    n = 0;
    forever begin
      @(negedge clk);
      if (s_rd_valid) begin
        check(tag, s_rd_data, exp);
        break;
      end
      n++;
      if (n > 20) begin
        check({tag, "_timeout"}, {63'd0, s_rd_valid}, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    // Reset state, and in_ready rising only after the first edge out of reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    rst = 1'b0;
    #1;
    check("pre_edge_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    check("post_edge_in_ready", {63'd0, in_ready}, 64'd1);

    // Legacy 8-bit wrap: each row equals A
    issue(MMAC_OP_CLR, 0, '0, '0, 1'b0);
    issue(MMAC_OP_MAC, 0, 32'h04030201, 32'h01010101, 1'b0);
    for (int r = 0; r < 4; r++) issue(MMAC_OP_READ, r, '0, '0, 1'b0);
    drain();

    // Wrap versus saturate on unsigned overflow
    issue(MMAC_OP_CLR, 0, '0, '0, 1'b0);
    issue(MMAC_OP_LOAD, 0, 32'h000000F0, '0, 1'b0);
    issue(MMAC_OP_MAC, 0, 32'h00000020, 32'h00000001, 1'b0);
    issue(MMAC_OP_READ, 0, '0, '0, 1'b0);
    drain();
    issue(MMAC_OP_CLR, 0, '0, '0, 1'b0);
    issue(MMAC_OP_LOAD, 0, 32'h000000F0, '0, 1'b0);
    issue(MMAC_OP_MAC, 0, 32'h00000020, 32'h00000001, 1'b1);
    issue(MMAC_OP_READ, 0, '0, '0, 1'b0);
    drain();

    // Back-to-back CLR, MAC, MAC, READ
    issue(MMAC_OP_CLR, 0, '0, '0, 1'b0);
    issue(MMAC_OP_MAC, 0, 32'h01010101, 32'h02020202, 1'b0);
    issue(MMAC_OP_MAC, 0, 32'h01010101, 32'h02020202, 1'b0);
    issue(MMAC_OP_READ, 2, '0, '0, 1'b0);
    drain();

    // Backpressure: held row is stable and a queued MAC waits behind it
    issue(MMAC_OP_CLR, 0, '0, '0, 1'b0);
    issue(MMAC_OP_LOAD, 0, 32'h11223344, '0, 1'b0);
    rd_ready = 1'b0;
    issue(MMAC_OP_READ, 0, '0, '0, 1'b0);
    issue(MMAC_OP_MAC, 0, 32'h01010101, 32'h00000001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_rd_valid", {63'd0, rd_valid}, 64'd1);
      check("bp_rd_data", {32'd0, rd_data}, 64'h11223344);
    end
    @(posedge clk); #1;
    rd_ready = 1'b1;
    issue(MMAC_OP_READ, 0, '0, '0, 1'b0);
    drain();

    // Random ops with random read backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(mmac_op_t'(2'($urandom_range(0, 3))), int'($urandom_range(0, 3)),
            $urandom, $urandom & 32'h03030303, 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    rd_ready = 1'b1;
    for (int r = 0; r < 4; r++) issue(MMAC_OP_READ, r, '0, '0, 1'b0);
    drain();

    // Reset with a MAC in S1 and a READ completing in S2
    issue(MMAC_OP_CLR, 0, '0, '0, 1'b0);
    issue(MMAC_OP_LOAD, 0, 32'h000000FF, '0, 1'b0);
    issue(MMAC_OP_MAC, 0, 32'h00000001, 32'h00000001, 1'b0);
    issue(MMAC_OP_READ, 0, '0, '0, 1'b0);
    issue(MMAC_OP_MAC, 0, 32'h01010101, 32'h01010101, 1'b0);
    check("pre_rst_ovf", {63'd0, ovf}, {63'd0, movf});
    rst = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check("midrst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("midrst_rd_data", {32'd0, rd_data}, 64'd0);
    check("midrst_ovf", {63'd0, ovf}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) issue(MMAC_OP_READ, r, '0, '0, 1'b0);
    drain();

    // Signed 16-bit accumulators
    s_issue(MMAC_OP_CLR, 0, '0, '0, 1'b0);
    s_issue(MMAC_OP_MAC, 0, 32'h000000FF, 32'h00000003, 1'b0);
    s_read(0, 64'h0000_0000_0000_FFFD, "s_row0_neg");
    s_read(1, 64'h0, "s_row1_zero");
    check("s_ovf_clear", {63'd0, s_ovf}, 64'd0);
    s_issue(MMAC_OP_CLR, 0, '0, '0, 1'b0);
    s_issue(MMAC_OP_MAC, 0, 32'h00000080, 32'h00000080, 1'b1);
    s_read(0, 64'h0000_0000_0000_4000, "s_row0_pos");
    s_issue(MMAC_OP_MAC, 0, 32'h00000080, 32'h00000080, 1'b1);
    s_read(0, 64'h0000_0000_0000_7FFF, "s_row0_sat");
    check("s_ovf_set", {63'd0, s_ovf}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
